// File: rtl/mux2_rr_arbiter_if.sv
// Bus bundle for the two-requester round-robin 2:1 mux arbiter.
// master: the arbiter's view; slave: the requesters/consumer side.
interface mux2_rr_arbiter_if;
   logic       req0;
   logic [1:0] data0;
   logic       ready0;
   logic       req1;
   logic [1:0] data1;
   logic       ready1;
   logic [1:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       sel;
   logic [1:0] grant;

   modport master (
      input  req0, data0, req1, data1, out_ready,
      output ready0, ready1, out_data, out_valid, sel, grant
   );

   modport slave (
      output req0, data0, req1, data1, out_ready,
      input  ready0, ready1, out_data, out_valid, sel, grant
   );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a registered-select 2:1 mux.
// A grant is held for up to MAX_BURST transfers, then released to the other side or idle.
module mux2_rr_arbiter #(
   parameter int unsigned MAX_BURST = 4  // legal range 1..15
) (
   input  logic               clk,
   input  logic               rst_n,
   mux2_rr_arbiter_if.master  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   logic [1:0] state_q, state_d;
   logic [3:0] count_q, count_d;
   logic       last_q,  last_d;
   logic       sel_q,   sel_d;
   logic [1:0] grant_q, grant_d;

   logic owner;
   logic own_req;
   logic other_req;
   logic xfer;
   logic release_gnt;

   // Per-owner view of the handshake while a grant is held.
   always_comb begin
      owner       = (state_q == GNT1);
      own_req     = owner ? bus.req1 : bus.req0;
      other_req   = owner ? bus.req0 : bus.req1;
      xfer        = own_req & bus.out_ready;
      release_gnt = (xfer && (count_q == LAST_BEAT)) || !own_req;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (bus.req0) begin
               state_d = GNT0;
            end else if (bus.req1) begin
               state_d = GNT1;
            end
         end
         GNT0, GNT1: begin
            if (release_gnt) begin
               // Go straight to the other side if it is waiting, otherwise idle.
               last_d  = owner;
               count_d = 4'd0;
               state_d = other_req ? (owner ? GNT0 : GNT1) : IDLE;
            end else if (xfer) begin
               count_d = count_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = 4'd0;
         end
      endcase
   end

   // sel holds its value through IDLE so it only moves on a grant change.
   always_comb begin
      sel_d   = sel_q;
      grant_d = 2'b00;
      unique case (state_d)
         GNT0: begin
            sel_d   = 1'b0;
            grant_d = 2'b01;
         end
         GNT1: begin
            sel_d   = 1'b1;
            grant_d = 2'b10;
         end
         default: begin
            sel_d   = sel_q;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      bus.sel       = sel_q;
      bus.grant     = grant_q;
      bus.out_data  = sel_q ? bus.data1 : bus.data0;
      bus.out_valid = (grant_q[0] & bus.req0) | (grant_q[1] & bus.req1);
      bus.ready0    = grant_q[0] & bus.req0 & bus.out_ready;
      bus.ready1    = grant_q[1] & bus.req1 & bus.out_ready;
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: per-cycle expected outputs and transfer words are
// queued as stimulus is driven and compared when the DUT presents them.
module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, out_ready;
   logic [1:0] data0, data1;

   int checks = 0;
   int errors = 0;

   logic       exp_sel [2];
   logic [7:0] vec_q [$];
   logic [1:0] xfer_q [$];

   always #5 clk = ~clk;

   mux2_rr_arbiter_if ia ();
   mux2_rr_arbiter_if ib ();

   assign ia.req0 = req0;
   assign ia.req1 = req1;
   assign ia.data0 = data0;
   assign ia.data1 = data1;
   assign ia.out_ready = out_ready;
   assign ib.req0 = req0;
   assign ib.req1 = req1;
   assign ib.data0 = data0;
   assign ib.data1 = data1;
   assign ib.out_ready = out_ready;

   mux2_rr_arbiter #(.MAX_BURST(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   mux2_rr_arbiter #(.MAX_BURST(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   // Packed as {grant, sel, out_valid, out_data, ready0, ready1}.
   function automatic logic [7:0] observe(input int which);
      if (which == 0) begin
         return {ia.grant, ia.sel, ia.out_valid, ia.out_data, ia.ready0, ia.ready1};
      end
      return {ib.grant, ib.sel, ib.out_valid, ib.out_data, ib.ready0, ib.ready1};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock cycle in which the given DUT is expected to show grant g.
   task automatic cyc(input int which, input logic [1:0] g, input string tag);
      logic       s, ov, r0, r1;
      logic [1:0] od;
      logic [7:0] got, want;
      data0 = 2'($urandom_range(0, 3));
      data1 = 2'($urandom_range(0, 3));
      if (g == 2'b01)      s = 1'b0;
      else if (g == 2'b10) s = 1'b1;
      else                 s = exp_sel[which];
      od = s ? data1 : data0;
      ov = ((g == 2'b01) & req0) | ((g == 2'b10) & req1);
      r0 = g[0] & req0 & out_ready;
      r1 = g[1] & req1 & out_ready;
      vec_q.push_back({g, s, ov, od, r0, r1});
      if (ov && out_ready) xfer_q.push_back(od);
      exp_sel[which] = s;
      @(negedge clk);
      got  = observe(which);
      want = vec_q.pop_front();
      chk(tag, got, want);
      if (got[4] && out_ready) begin
         checks++;
         assert (xfer_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_xfer: observed transfer of %b expected none", tag, got[3:2]);
         end
         if (xfer_q.size() != 0) chk({tag, "_word"}, {6'd0, got[3:2]}, {6'd0, xfer_q.pop_front()});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      out_ready = 1'b1;
      data0 = 2'b00;
      data1 = 2'b00;
      exp_sel[0] = 1'b0;
      exp_sel[1] = 1'b0;

      // Reset dominates even with both requests high.
      cyc(0, 2'b00, "reset_a");
      cyc(1, 2'b00, "reset_b");
      rst_n = 1'b1;

      // Tie from cycle 0: bursts of 4 alternate between requesters.
      cyc(0, 2'b00, "tie_c0");
      repeat (2) begin
         repeat (4) cyc(0, 2'b01, "tie_g0");
         repeat (4) cyc(0, 2'b10, "tie_g1");
      end
      req0 = 1'b0;
      req1 = 1'b0;
      cyc(0, 2'b01, "drop_req_g0");
      cyc(0, 2'b00, "drop_req_idle");

      // Lone requester 1: burst limit forces a one-cycle idle gap before re-grant.
      req1 = 1'b1;
      cyc(0, 2'b00, "solo_idle");
      repeat (4) cyc(0, 2'b10, "solo_g1");
      cyc(0, 2'b00, "solo_gap");
      repeat (4) cyc(0, 2'b10, "solo_regrant");
      req1 = 1'b0;
      cyc(0, 2'b00, "solo_done");

      // Back-pressure: grant and count hold, so exactly 3 more transfers end the burst.
      req0 = 1'b1;
      cyc(0, 2'b00, "stall_idle");
      cyc(0, 2'b01, "stall_pre");
      out_ready = 1'b0;
      repeat (5) cyc(0, 2'b01, "stall_hold");
      out_ready = 1'b1;
      repeat (3) cyc(0, 2'b01, "stall_resume");
      req0 = 1'b0;
      cyc(0, 2'b00, "stall_end");

      // req0 drops after 2 transfers with req1 waiting: direct switch, fresh count.
      req0 = 1'b1;
      cyc(0, 2'b00, "sw_idle");
      req1 = 1'b1;
      repeat (2) cyc(0, 2'b01, "sw_g0");
      req0 = 1'b0;
      cyc(0, 2'b01, "sw_release");
      repeat (3) cyc(0, 2'b10, "sw_g1");

      // Asynchronous reset mid-cycle during GNT1.
      #1;
      chk("pre_rst", observe(0), {2'b10, 1'b1, 1'b1, data1, 1'b0, 1'b1});
      rst_n = 1'b0;
      #1;
      chk("async_rst", observe(0), {2'b00, 1'b0, 1'b0, data0, 1'b0, 1'b0});
      exp_sel[0] = 1'b0;
      exp_sel[1] = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 2'b00, "rst_idle");
      cyc(0, 2'b01, "rst_first");

      // MAX_BURST=1 instance: strict alternation with no idle cycles.
      rst_n = 1'b0;
      exp_sel[1] = 1'b0;
      cyc(1, 2'b00, "b_rst");
      rst_n = 1'b1;
      cyc(1, 2'b00, "b_idle");
      repeat (3) begin
         cyc(1, 2'b01, "b_g0");
         cyc(1, 2'b10, "b_g1");
      end

      checks++;
      assert (xfer_q.size() == 0) else begin
         errors++;
         $error("FAIL xfer_drain: observed %0d pending words expected 0", xfer_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
